// File: rtl/efuse_load_ctrl.sv
// Efuse-to-register load sequencer: reads words over a req/ack handshake into a shadow buffer,
// then commits them to the register bank in one cycle. Define EFUSE_LOAD_PARITY_EN to read and check a trailing XOR parity word.
module efuse_load_ctrl #(
  parameter int unsigned   DW          = 8,
  parameter int unsigned   AW          = 8,
  parameter int unsigned   WORD_NUM    = 4,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int unsigned   TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load_start,
  output logic                   o_efuse_req,
  output logic [AW-1:0]          o_efuse_addr,
  input  logic                   i_efuse_ack,
  input  logic [DW-1:0]          i_efuse_rdata,
  output logic                   o_efuse_ctrl_reg_en,
  output logic [WORD_NUM*DW-1:0] o_lgc_wen,
  output logic [WORD_NUM*DW-1:0] o_lgc_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

`ifdef EFUSE_LOAD_PARITY_EN
  localparam int unsigned RD_NUM = WORD_NUM + 1;
`else
  localparam int unsigned RD_NUM = WORD_NUM;
`endif
  localparam int unsigned IW = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(RD_NUM - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_COMMIT} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [TW-1:0]          tcnt_q;
  logic [WORD_NUM*DW-1:0] shadow_q;
  logic                   done_q, err_q;
  logic                   ack_ok, last_word, check_ok;

  assign ack_ok    = (state_q == S_REQ) && i_efuse_ack;
  assign last_word = (idx_q == LAST_IDX);

`ifdef EFUSE_LOAD_PARITY_EN
  logic [DW-1:0] parity_q, xor_w;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                   parity_q <= '0;
    else if (ack_ok && last_word)   parity_q <= i_efuse_rdata;
  end

  // Parity word XOR all data words is zero exactly when the stored parity matches.
  always_comb begin
    xor_w = parity_q;
    for (int k = 0; k < WORD_NUM; k++) xor_w ^= shadow_q[k*DW +: DW];
  end
  assign check_ok = (xor_w == '0);
`else
  assign check_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_load_start) state_d = S_REQ;
      S_REQ: begin
        if (i_efuse_ack)             state_d = S_GAP;
        else if (tcnt_q == TO_LAST)  state_d = S_IDLE;
      end
      S_GAP: begin
        if (!last_word)    state_d = S_REQ;
        else if (check_ok) state_d = S_COMMIT;
        else               state_d = S_IDLE;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_efuse_req         = 1'b0;
    o_efuse_addr        = '0;
    o_efuse_ctrl_reg_en = 1'b0;
    o_lgc_wen           = '0;
    o_busy              = (state_q != S_IDLE);
    case (state_q)
      S_REQ: begin
        o_efuse_req  = 1'b1;
        o_efuse_addr = BASE_ADDR + AW'(idx_q);
      end
      S_COMMIT: begin
        o_efuse_ctrl_reg_en = 1'b1;
        o_lgc_wen           = '1;
      end
      default: ;
    endcase
  end

  // Sequencing registers: word index, per-REQ timeout counter and the sticky status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q  <= '0;
      tcnt_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_load_start) begin
          idx_q  <= '0;
          tcnt_q <= '0;
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
        S_REQ: if (!i_efuse_ack) begin
          if (tcnt_q == TO_LAST) err_q  <= 1'b1;
          else                   tcnt_q <= tcnt_q + 1'b1;
        end
        S_GAP: begin
          tcnt_q <= '0;
          if (!last_word)     idx_q <= idx_q + 1'b1;
          else if (!check_ok) err_q <= 1'b1;
        end
        S_COMMIT: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the shadow buffer is a plain register array with reset, since a reset mid-load must clear it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
    end else begin
      for (int k = 0; k < WORD_NUM; k++) begin
        if (ack_ok && (idx_q == IW'(k))) shadow_q[k*DW +: DW] <= i_efuse_rdata;
      end
    end
  end

  assign o_lgc_wdata = shadow_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Self-checking bench for efuse_load_ctrl: an efuse responder model plus directed loads whose
// expected outcome is queued on start and compared when the load finishes.
module tb_efuse_load_ctrl;
  localparam int          DW    = 8;
  localparam int          AW    = 8;
  localparam int          WN    = 4;
  localparam logic [7:0]  BASE  = 8'hFE;
  localparam int          TOC   = 5;
`ifdef EFUSE_LOAD_PARITY_EN
  localparam int          NRD   = WN + 1;
`else
  localparam int          NRD   = WN;
`endif

  logic              clk, rst_n, start;
  logic              req, ack, ctrl_en, busy, done, err;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     rdata;
  logic [WN*DW-1:0]  wen, wdata;

  efuse_load_ctrl #(
    .DW(DW), .AW(AW), .WORD_NUM(WN), .BASE_ADDR(BASE), .TIMEOUT_CYC(TOC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(start),
    .o_efuse_req(req), .o_efuse_addr(addr), .i_efuse_ack(ack), .i_efuse_rdata(rdata),
    .o_efuse_ctrl_reg_en(ctrl_en), .o_lgc_wen(wen), .o_lgc_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ok;
    logic [31:0] wdata;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] efuse_mem [0:255];

  // Efuse responder: acks after ack_delay REQ cycles (never if negative), optional spurious acks.
  int ack_delay = 0;
  bit spurious  = 1'b0;
  int wait_cnt  = 0;
  initial begin
    ack   = 1'b0;
    rdata = '0;
  end
  always @(negedge clk) begin
    if (req) begin
      if (ack_delay >= 0 && wait_cnt == ack_delay) begin
        ack   = 1'b1;
        rdata = efuse_mem[addr];
      end else begin
        ack   = 1'b0;
        rdata = 8'h5C;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      ack      = spurious;
      rdata    = 8'hEE;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor_words(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic set_words_par(input logic [31:0] w, input logic [7:0] par);
    logic [7:0] a;
    for (int k = 0; k < WN; k++) begin
      a = BASE + 8'(k);
      efuse_mem[a] = w[k*8 +: 8];
    end
    a = BASE + 8'(WN);
    efuse_mem[a] = par;
  endtask

  task automatic set_words(input logic [31:0] w);
    set_words_par(w, xor_words(w));
  endtask

  // Runs one load from a start pulse until busy drops, monitoring the handshake and commit.
  task automatic do_load(input string tag, input bit exp_ok, input logic [31:0] exp_wdata,
                         input int exp_commit_cyc, input int exp_run, input bit restart);
    exp_t       e;
    int         commits = 0, commit_cyc = -1, wen_bad = 0, addr_bad = 0, gap_bad = 0;
    int         phases = 0, run = 0, max_run = 0, gap_len = 0;
    bit         prev_req = 1'b0, finished = 1'b0;
    logic [7:0] held_addr, exp_addr;
    logic [31:0] cw = '0;

    e.ok    = exp_ok;
    e.wdata = exp_wdata;
    sb.push_back(e);
    start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (req) begin
        if (!prev_req) begin
          if (phases > 0 && gap_len != 1) gap_bad++;
          exp_addr  = BASE + 8'(phases);
          if (addr !== exp_addr) addr_bad++;
          held_addr = addr;
          phases++;
          run = 0;
        end else if (addr !== held_addr) begin
          addr_bad++;
        end
        run++;
        if (run > max_run) max_run = run;
        gap_len = 0;
      end else begin
        gap_len++;
      end
      prev_req = req;
      if (ctrl_en) begin
        commits++;
        commit_cyc = cyc;
        cw = wdata;
        if (wen !== '1) wen_bad++;
      end else if (wen !== '0) begin
        wen_bad++;
      end
      start = restart && busy && (cyc == 2 || cyc == 5);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_finished"}, finished, 1'b1);
    e = sb.pop_front();
    check({tag, "_commits"}, commits, e.ok ? 1 : 0);
    check({tag, "_done"}, done, e.ok);
    check({tag, "_err"}, err, !e.ok);
    check({tag, "_wdata"}, wdata, e.wdata);
    check({tag, "_wen"}, wen_bad, 0);
    check({tag, "_addr"}, addr_bad, 0);
    check({tag, "_gap"}, gap_bad, 0);
    check({tag, "_req_run"}, max_run, exp_run);
    if (e.ok) begin
      check({tag, "_phases"}, phases, NRD);
      check({tag, "_commit_data"}, cw, e.wdata);
      check({tag, "_commit_cyc"}, commit_cyc, exp_commit_cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", req, 1'b0);
    check("rst_addr", addr, 8'h00);
    check("rst_wen", wen, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ctrl_en", ctrl_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    set_words(32'h44332211);
    ack_delay = 0;
    do_load("imm", 1'b1, 32'h44332211, 2*NRD + 1, 1, 1'b0);

    set_words(32'h3CC35AA5);
    ack_delay = 3;
    do_load("dly3", 1'b1, 32'h3CC35AA5, 5*NRD + 1, 4, 1'b0);

    ack_delay = -1;
    do_load("tmo", 1'b0, 32'h3CC35AA5, -1, TOC, 1'b0);
    check("tmo_req_low", req, 1'b0);

    set_words(32'h44332211);
    ack_delay = 0;
    spurious  = 1'b1;
    do_load("ignore", 1'b1, 32'h44332211, 2*NRD + 1, 1, 1'b1);
    spurious  = 1'b0;

`ifdef EFUSE_LOAD_PARITY_EN
    set_words_par(32'h0201F00F, 8'hFC);
    do_load("par_ok", 1'b1, 32'h0201F00F, 2*NRD + 1, 1, 1'b0);
    set_words_par(32'h0201F00F, 8'hFD);
    set_words_par(32'h0201F00F, 8'hFD);
    do_load("par_bad", 1'b0, 32'h0201F00F, -1, 1, 1'b0);
`endif

    // Reset during the third REQ, then a clean load afterwards.
    set_words(32'h87654321);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_third_req", req, 1'b1);
    check("mid_third_addr", addr, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", req, 1'b0);
    check("mid_rst_addr", addr, 8'h00);
    check("mid_rst_wdata", wdata, 32'h0);
    check("mid_rst_ctrl_en", ctrl_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load("post_rst", 1'b1, 32'h87654321, 2*NRD + 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/efuse_load_ctrl.md
# efuse_load_ctrl

Fuse-to-register load sequencer that drives the logic write port of the efuse-backed rww registers. On a start pulse it reads WORD_NUM words from the efuse macro through a req/ack handshake into a shadow buffer. It then commits all words to the register bank in one cycle by pulsing the per-bit logic write enables and the efuse control enable. It sits between the efuse macro interface and the register bank, under control of the power-up/mode controller.

## Interface
- DW, 8, data width of one efuse word / one register
- AW, 8, efuse address width
- WORD_NUM, 4, number of data words loaded (>=1)
- BASE_ADDR, {AW{1'b0}}, efuse address of word 0; word k at BASE_ADDR+k
- TIMEOUT_CYC, 255, max cycles req may stay high without ack (>=2)

- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_load_start  in  1  single-cycle load request
- o_efuse_req  out  1  efuse read request, level, held until ack
- o_efuse_addr  out  AW  efuse read address, stable while o_efuse_req=1
- i_efuse_ack  in  1  read acknowledge, valid only while o_efuse_req=1
- i_efuse_rdata  in  DW  read data, valid in the i_efuse_ack cycle
- o_efuse_ctrl_reg_en  out  1  register bank logic-write qualifier, 1 in commit cycle only
- o_lgc_wen  out  WORD_NUM*DW  per-bit logic write enables, slice k -> register k
- o_lgc_wdata  out  WORD_NUM*DW  shadow buffer, slice k = word k
- o_busy  out  1  load in progress
- o_done  out  1  last load committed successfully (level)
- o_err  out  1  last load failed (level)

## Operation
- FSM states:
  - IDLE:
    - i_load_start -> REQ, idx=0.
    - Start clears o_done, o_err, and the timeout counter.
  - REQ:
    - o_efuse_req=1, o_efuse_addr=BASE_ADDR+idx.
    - On i_efuse_ack: capture i_efuse_rdata into slot idx, then -> GAP.
    - Otherwise the timeout counter increments. At TIMEOUT_CYC cycles without ack: o_err<=1 -> IDLE.
  - GAP:
    - o_efuse_req=0 for exactly one cycle.
    - If idx < last index: idx++, -> REQ.
    - Else -> COMMIT, or -> IDLE with o_err<=1 on check failure (see Configuration).
  - COMMIT:
    - o_lgc_wen = all ones and o_efuse_ctrl_reg_en=1 for one cycle.
    - o_done<=1, -> IDLE.
- o_busy=1 in REQ, GAP and COMMIT.
- i_load_start outside IDLE is ignored.
- i_efuse_ack outside REQ is ignored.
- Timeout counter resets on entry to each REQ.
- Shadow buffer:
  - Slot k is overwritten only by its own ack capture.
  - On error the shadow buffer keeps partial data, but no commit occurs and registers are untouched.
- idx width is clog2 of the total word count, minimum 1 bit. Addresses wrap modulo 2^AW.
- Reset values: FSM=IDLE, idx=0, shadow=0, and all outputs 0. This includes o_efuse_req, o_efuse_addr, o_lgc_wen, o_lgc_wdata, o_efuse_ctrl_reg_en, o_busy, o_done and o_err.
- Reset mid-load aborts immediately: req drops asynchronously, there is no commit, and the shadow buffer is cleared.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from input to output.
- i_load_start in cycle 0 -> o_efuse_req=1 in cycle 1.
- Ack sampled at a clock edge -> data captured and req=0 in the next cycle (GAP).
- Minimum spacing is 2 cycles per word when ack is returned in the first REQ cycle.
- With WORD_NUM=4, no parity and immediate acks:
  - REQ in cycles 1, 3, 5, 7; GAP in cycles 2, 4, 6, 8.
  - COMMIT in cycle 9; o_done=1 and o_busy=0 from cycle 10.
- Timeout: req stays high for exactly TIMEOUT_CYC cycles. o_err=1 and req=0 in the following cycle.

## Configuration
- EFUSE_LOAD_PARITY_EN defined:
  - One extra word is read at BASE_ADDR+WORD_NUM, for WORD_NUM+1 reads in total.
  - The extra word must equal the XOR of all data words.
  - Mismatch in the final GAP -> o_err=1, no commit.
  - The parity word is held internally and is never driven on o_lgc_wdata.
- Undefined: WORD_NUM reads, no check, and the final GAP always proceeds to COMMIT.

## Test plan
- Immediate-ack load, efuse data 0x11, 0x22, 0x33, 0x44 (no parity):
  - Commit in cycle 9; o_lgc_wdata=0x44332211; o_lgc_wen all ones for 1 cycle; o_done=1.
- Ack delayed 3 cycles per word:
  - o_efuse_addr stays stable while req is high; req drops for exactly 1 cycle between words; data is correct.
- No ack with TIMEOUT_CYC=5:
  - req high for 5 cycles, then o_err=1; o_lgc_wen and o_efuse_ctrl_reg_en never asserted.
- i_load_start repeated while busy, plus a spurious ack in a GAP cycle:
  - Both ignored; the sequence and data match the first scenario.
- Parity build, words 0x0F, 0xF0, 0x01, 0x02 with parity word 0xFC:
  - Commit occurs.
  - Parity word 0xFD instead: o_err=1, no commit.
- i_rst_n asserted during the third REQ:
  - All outputs 0 immediately.
  - After release, a new start performs a complete clean load.
